// File: rtl/ann_layer_engine_if.sv
// Handshake bundle for ann_layer_engine: weight writes, serial input samples,
// parallel result output and weight-update deltas.
interface ann_layer_engine_if #(
   parameter int N_IN  = 30,
   parameter int N_OUT = 5,
   parameter int DW    = 10
);
   localparam int WA = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;

   logic                  w_we;
   logic [WA-1:0]         w_addr;
   logic [DW-1:0]         w_wdata;
   logic                  in_valid;
   logic                  in_ready;
   logic [DW-1:0]         in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [N_OUT*DW-1:0]   out_data;
   logic                  upd_valid;
   logic                  upd_ready;
   logic [N_OUT*DW-1:0]   upd_delta;
   logic                  busy;
   logic                  sat_flag;

   modport slave (
      input  w_we, w_addr, w_wdata, in_valid, in_data, out_ready, upd_valid, upd_delta,
      output in_ready, out_valid, out_data, upd_ready, busy, sat_flag
   );

   modport master (
      output w_we, w_addr, w_wdata, in_valid, in_data, out_ready, upd_valid, upd_delta,
      input  in_ready, out_valid, out_data, upd_ready, busy, sat_flag
   );
endinterface

// File: rtl/ann_layer_engine.sv
// One fully-connected layer: N_OUT neurons accumulate N_IN serial inputs in
// parallel, then shift/saturate/activate; also applies delta-scaled weight updates.
module ann_layer_engine #(
   parameter int N_IN  = 30,
   parameter int N_OUT = 5,
   parameter int DW    = 10,
   parameter int FRAC  = 6,
   parameter int ACT   = 0
) (
   input logic               Clock,
   input logic               Rst,
   ann_layer_engine_if.slave bus
);
   localparam int KW   = $clog2(N_IN + 1);
   localparam int XI   = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int PW   = 2 * DW;
   localparam int AW   = 2 * DW + $clog2(N_IN);
   localparam int SMAX = 2 ** (DW - 1) - 1;
   localparam int SMIN = -(2 ** (DW - 1));
   localparam int HALF = 2 ** (FRAC - 1);
   localparam int ONE  = 2 ** FRAC;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_ACT, S_OUT, S_UPD} state_t;

   state_t                state, state_nx;
   logic [KW-1:0]         k;
   logic [XI-1:0]         ki;
   logic signed [DW-1:0]  w     [N_OUT][N_IN];
   logic signed [DW-1:0]  x_buf [N_IN];
   logic signed [DW-1:0]  d_lat [N_OUT];
   logic signed [PW-1:0]  prod  [N_OUT];
   logic signed [AW-1:0]  acc   [N_OUT];
   logic signed [PW-1:0]  mul   [N_OUT];
   logic signed [AW-1:0]  sh    [N_OUT];
   logic signed [DW-1:0]  s     [N_OUT];
   logic signed [DW+1:0]  t     [N_OUT];
   logic signed [DW-1:0]  y     [N_OUT];
   logic signed [PW-1:0]  dmul  [N_OUT];
   logic signed [PW:0]    wsum  [N_OUT];
   logic signed [DW-1:0]  w_upd [N_OUT];
   logic [N_OUT-1:0]      sat_j;
   logic [N_OUT*DW-1:0]   out_q;
   logic                  sat_q;
   logic                  in_rdy, upd_rdy, in_hs, upd_hs, last_in;

   assign ki      = (k < KW'(N_IN)) ? XI'(k) : '0;
   assign in_hs   = bus.in_valid & in_rdy;
   assign upd_hs  = bus.upd_valid & upd_rdy;
   assign last_in = (state == S_LOAD) ? (k == KW'(N_IN - 1)) : (N_IN == 1);

   always_comb begin
      state_nx = state;
      in_rdy   = 1'b0;
      upd_rdy  = 1'b0;
      case (state)
         S_IDLE: begin
            upd_rdy = 1'b1;
            in_rdy  = !bus.upd_valid;
            if (bus.upd_valid)     state_nx = S_UPD;
            else if (bus.in_valid) state_nx = last_in ? S_MAC : S_LOAD;
         end
         S_LOAD: begin
            in_rdy = 1'b1;
            if (bus.in_valid && last_in) state_nx = S_MAC;
         end
         // k runs one past the last tap to drain the product register
         S_MAC:   if (k == KW'(N_IN)) state_nx = S_ACT;
         S_ACT:   state_nx = S_OUT;
         S_OUT:   if (bus.out_ready) state_nx = S_IDLE;
         S_UPD:   if (k == KW'(N_IN - 1)) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      for (int j = 0; j < N_OUT; j++) begin
         mul[j]   = PW'(w[j][ki]) * PW'(x_buf[ki]);
         sh[j]    = acc[j] >>> FRAC;
         sat_j[j] = 1'b0;
         if (sh[j] > AW'(SMAX)) begin
            s[j]     = DW'(SMAX);
            sat_j[j] = 1'b1;
         end else if (sh[j] < AW'(SMIN)) begin
            s[j]     = DW'(SMIN);
            sat_j[j] = 1'b1;
         end else begin
            s[j] = sh[j][DW-1:0];
         end
         t[j] = (DW+2)'(s[j] >>> 2) + (DW+2)'(HALF);
         if (ACT == 0) begin
            if (t[j][DW+1])                y[j] = '0;
            else if (t[j] > (DW+2)'(ONE))  y[j] = DW'(ONE);
            else                           y[j] = t[j][DW-1:0];
         end else if (ACT == 1) begin
            y[j] = s[j][DW-1] ? '0 : s[j];
         end else begin
            y[j] = s[j];
         end
         dmul[j] = PW'(d_lat[j]) * PW'(x_buf[ki]);
         wsum[j] = (PW+1)'(dmul[j] >>> FRAC) + (PW+1)'(w[j][ki]);
         if (wsum[j] > (PW+1)'(SMAX))      w_upd[j] = DW'(SMAX);
         else if (wsum[j] < (PW+1)'(SMIN)) w_upd[j] = DW'(SMIN);
         else                              w_upd[j] = wsum[j][DW-1:0];
      end
   end

   always_ff @(posedge Clock) begin
      if (Rst) begin
         state <= S_IDLE;
         k     <= '0;
         out_q <= '0;
         sat_q <= 1'b0;
         for (int j = 0; j < N_OUT; j++) begin
            d_lat[j] <= '0;
            prod[j]  <= '0;
            acc[j]   <= '0;
            for (int i = 0; i < N_IN; i++) w[j][i] <= '0;
         end
         for (int i = 0; i < N_IN; i++) x_buf[i] <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: begin
               if (upd_hs) begin
                  k <= '0;
                  for (int j = 0; j < N_OUT; j++) d_lat[j] <= bus.upd_delta[j*DW +: DW];
               end else if (in_hs) begin
                  x_buf[0] <= bus.in_data;
                  k        <= last_in ? '0 : KW'(1);
               end
               // decode never matches addresses at or beyond N_IN*N_OUT
               if (bus.w_we) begin
                  for (int j = 0; j < N_OUT; j++)
                     for (int i = 0; i < N_IN; i++)
                        if (int'(bus.w_addr) == j * N_IN + i) w[j][i] <= bus.w_wdata;
               end
            end
            S_LOAD: begin
               if (in_hs) begin
                  x_buf[ki] <= bus.in_data;
                  k         <= last_in ? '0 : k + 1'b1;
               end
            end
            S_MAC: begin
               k <= (k == KW'(N_IN)) ? '0 : k + 1'b1;
               for (int j = 0; j < N_OUT; j++) begin
                  acc[j]  <= acc[j] + AW'(prod[j]);
                  prod[j] <= (k < KW'(N_IN)) ? mul[j] : '0;
               end
            end
            S_ACT: begin
               for (int j = 0; j < N_OUT; j++) out_q[j*DW +: DW] <= y[j];
               sat_q <= |sat_j;
            end
            S_UPD: begin
               k <= (k == KW'(N_IN - 1)) ? '0 : k + 1'b1;
               for (int j = 0; j < N_OUT; j++) w[j][ki] <= w_upd[j];
            end
            default: ;
         endcase
         if (state_nx == S_MAC && state != S_MAC) begin
            sat_q <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
               acc[j]  <= '0;
               prod[j] <= '0;
            end
         end
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.upd_ready = upd_rdy;
   assign bus.out_valid = (state == S_OUT);
   assign bus.out_data  = out_q;
   assign bus.busy      = (state != S_IDLE);
   assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_ann_layer_engine.sv
// Directed bench: identity and sigmoid instances share stimulus; a plain-arithmetic
// layer model predicts results, checked every output cycle plus literal pins.
module tb_ann_layer_engine;
   localparam int N_IN = 3, N_OUT = 2, DW = 10, FRAC = 6;
   localparam int NW   = N_IN * N_OUT;
   localparam int AB   = $clog2(NW);
   localparam int SMAX = 511, SMIN = -512;

   logic Clock = 1'b0;
   logic Rst   = 1'b1;
   always #5 Clock = ~Clock;

   logic                w_we, in_valid, out_ready, upd_valid;
   logic [AB-1:0]       w_addr;
   logic [DW-1:0]       w_wdata, in_data;
   logic [N_OUT*DW-1:0] upd_delta;

   ann_layer_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bi ();
   ann_layer_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bs ();

   assign bi.w_we = w_we;           assign bs.w_we = w_we;
   assign bi.w_addr = w_addr;       assign bs.w_addr = w_addr;
   assign bi.w_wdata = w_wdata;     assign bs.w_wdata = w_wdata;
   assign bi.in_valid = in_valid;   assign bs.in_valid = in_valid;
   assign bi.in_data = in_data;     assign bs.in_data = in_data;
   assign bi.out_ready = out_ready; assign bs.out_ready = out_ready;
   assign bi.upd_valid = upd_valid; assign bs.upd_valid = upd_valid;
   assign bi.upd_delta = upd_delta; assign bs.upd_delta = upd_delta;

   ann_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACT(2))
      u_id (.Clock(Clock), .Rst(Rst), .bus(bi.slave));
   ann_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACT(0))
      u_sg (.Clock(Clock), .Rst(Rst), .bus(bs.slave));

   // layer model
   int mw [N_OUT][N_IN];
   int mx [N_IN];
   int sx [N_IN];
   int e_id [N_OUT];
   int e_sg [N_OUT];
   int e_sat;
   bit e_pend;
   int n_chk, n_err;

   function automatic longint fdiv(input longint a, input longint b);
      longint q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
      return q;
   endfunction

   function automatic int clampi(input longint v, input int lo, input int hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return int'(v);
   endfunction

   function automatic void m_clear();
      for (int j = 0; j < N_OUT; j++)
         for (int i = 0; i < N_IN; i++) mw[j][i] = 0;
      for (int i = 0; i < N_IN; i++) mx[i] = 0;
      e_pend = 0;
   endfunction

   function automatic void m_infer();
      e_sat = 0;
      for (int j = 0; j < N_OUT; j++) begin
         longint sum = 0;
         longint q;
         for (int i = 0; i < N_IN; i++) sum += longint'(mw[j][i]) * mx[i];
         q = fdiv(sum, 2 ** FRAC);
         if (q > SMAX || q < SMIN) e_sat = 1;
         e_id[j] = clampi(q, SMIN, SMAX);
         e_sg[j] = clampi(2 ** (FRAC - 1) + fdiv(e_id[j], 4), 0, 2 ** FRAC);
      end
   endfunction

   function automatic void m_update(input int d0, input int d1);
      int d [N_OUT];
      d[0] = d0; d[1] = d1;
      for (int j = 0; j < N_OUT; j++)
         for (int i = 0; i < N_IN; i++)
            mw[j][i] = clampi(mw[j][i] + fdiv(longint'(d[j]) * mx[i], 2 ** FRAC), SMIN, SMAX);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int g_id(input int j);
      logic signed [DW-1:0] v;
      v = bi.out_data[j*DW +: DW];
      return int'(v);
   endfunction

   function automatic int g_sg(input int j);
      logic signed [DW-1:0] v;
      v = bs.out_data[j*DW +: DW];
      return int'(v);
   endfunction

   always @(negedge Clock) begin
      if (!Rst && bi.out_valid) begin
         if (!e_pend) begin
            chk("stray_out_valid", 1, 0);
         end else begin
            for (int j = 0; j < N_OUT; j++) begin
               chk($sformatf("id_out%0d", j), g_id(j), e_id[j]);
               chk($sformatf("sg_out%0d", j), g_sg(j), e_sg[j]);
            end
            chk("id_sat_flag", bi.sat_flag, e_sat);
            chk("sg_sat_flag", bs.sat_flag, e_sat);
            chk("sg_out_valid", bs.out_valid, 1);
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      tick();
      tick();
      Rst = 1'b0;
      m_clear();
   endtask

   task automatic wr(input int a, input int d);
      w_we = 1'b1; w_addr = AB'(a); w_wdata = DW'(d);
      tick();
      w_we = 1'b0;
      if (a < NW) mw[a / N_IN][a % N_IN] = d;
   endtask

   task automatic send_inputs();
      for (int k = 0; k < N_IN; k++) begin
         int b = 0;
         in_valid = 1'b1;
         in_data  = DW'(sx[k]);
         while (!bi.in_ready && b < 100) begin tick(); b++; end
         if (b >= 100) chk("in_ready_timeout", b, 0);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic run();
      int n = 0;
      send_inputs();
      mx = sx;
      m_infer();
      e_pend = 1;
      while (!bi.out_valid && n < 50) begin tick(); n++; end
      chk("latency", n, N_IN + 2);
   endtask

   task automatic take();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      e_pend = 0;
      chk("post_hs_valid", bi.out_valid, 0);
      chk("post_hs_in_ready", bi.in_ready, 1);
   endtask

   task automatic upd(input int d0, input int d1);
      int b = 0;
      upd_valid = 1'b1;
      upd_delta = {DW'(d1), DW'(d0)};
      while (!bi.upd_ready && b < 50) begin tick(); b++; end
      tick();
      upd_valid = 1'b0;
      m_update(d0, d1);
      b = 0;
      while (bi.busy && b < 50) begin tick(); b++; end
      chk("upd_done", bi.busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_chk = 0; n_err = 0;
      w_we = 0; w_addr = '0; w_wdata = '0; in_valid = 0; in_data = '0;
      out_ready = 0; upd_valid = 0; upd_delta = '0;
      do_reset();
      chk("rst_busy", bi.busy, 0);
      chk("rst_out_valid", bi.out_valid, 0);
      chk("rst_in_ready", bi.in_ready, 1);
      chk("rst_upd_ready", bi.upd_ready, 1);
      chk("rst_sat_flag", bi.sat_flag, 0);
      chk("rst_out_data", int'(bi.out_data), 0);

      // basic identity inference; address 6 lies outside the weight array
      wr(0, 64); wr(1, 64); wr(2, 64); wr(3, -64); wr(4, 0); wr(5, 0);
      wr(6, 77);
      sx = '{64, 128, -64};
      run();
      chk("r29_out0", g_id(0), 128);
      chk("r29_out1", g_id(1), -64);
      chk("r29_sat", bi.sat_flag, 0);
      chk("r29_sg0", g_sg(0), 64);
      chk("r29_sg1", g_sg(1), 16);
      take();

      // update and input offered together: update wins, input is held
      in_valid = 1'b1; in_data = DW'(sx[0]);
      upd_valid = 1'b1; upd_delta = {DW'(-32), DW'(64)};
      #1;
      chk("both_in_ready", bi.in_ready, 0);
      chk("both_upd_ready", bi.upd_ready, 1);
      tick();
      upd_valid = 1'b0;
      m_update(64, -32);
      chk("upd_taken_busy", bi.busy, 1);
      chk("upd_in_ready", bi.in_ready, 0);
      chk("m_w00", mw[0][0], 128);
      chk("m_w01", mw[0][1], 192);
      chk("m_w10", mw[1][0], -96);
      chk("m_w12", mw[1][2], 32);
      run();
      chk("r33_out0", g_id(0), 511);
      chk("r33_out1", g_id(1), -256);
      chk("r33_sat", bi.sat_flag, 1);
      take();

      // full-scale saturation, then a long output stall with a write attempt
      for (int a = 0; a < NW; a++) wr(a, 511);
      sx = '{511, 511, 511};
      run();
      chk("r30_out0", g_id(0), 511);
      chk("r30_out1", g_id(1), 511);
      chk("r30_sat", bi.sat_flag, 1);
      for (int c = 0; c < 10; c++) begin
         chk("hold_valid", bi.out_valid, 1);
         chk("hold_in_ready", bi.in_ready, 0);
         chk("hold_upd_ready", bi.upd_ready, 0);
         chk("hold_out0", g_id(0), 511);
         w_we = (c == 3); w_addr = '0; w_wdata = DW'(5);
         tick();
      end
      w_we = 1'b0;
      take();
      sx = '{1, 0, 0};
      run();
      chk("no_write_in_out", g_id(0), 7);
      take();

      // sigmoid operating points including both clamps
      wr(0, 64); wr(1, 0); wr(2, 0); wr(3, -64); wr(4, 0); wr(5, 0);
      sx = '{0, 0, 0};
      run();
      chk("sg_zero", g_sg(0), 32);
      take();
      sx = '{128, 0, 0};
      run();
      chk("sg_128", g_sg(0), 64);
      chk("sg_m128", g_sg(1), 0);
      take();
      sx = '{-256, 0, 0};
      run();
      chk("sg_m256", g_sg(0), 0);
      chk("sg_256", g_sg(1), 64);
      chk("id_m256", g_id(0), -256);
      take();

      // reset in the middle of accumulation
      sx = '{64, 64, 64};
      send_inputs();
      tick();
      chk("mac_busy", bi.busy, 1);
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      m_clear();
      chk("abort_busy", bi.busy, 0);
      chk("abort_out_valid", bi.out_valid, 0);
      chk("abort_in_ready", bi.in_ready, 1);
      repeat (8) tick();
      upd(32, 32);
      sx = '{100, 100, 100};
      run();
      chk("post_rst_out0", g_id(0), 0);
      chk("post_rst_out1", g_id(1), 0);
      chk("post_rst_sg0", g_sg(0), 32);
      take();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
